note_sprite_scheduler: RTL

//  Owns the falling-note sprite slots drawn over the background by the VGA pipeline.

---
 rtl/strum_vga_pkg.sv | 28 ++
 rtl/spawn_fifo.sv | 64 ++++++
 rtl/note_sprite_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/strum_vga_pkg.sv
// Shared constants and FSM encoding for the falling-note sprite logic.
//   SCREEN_W/SCREEN_H : visible area; a note retires once its y reaches SCREEN_H
//   SPRITE_SIZE       : square sprite edge in pixels
//   NUM_LANES         : lanes a note can spawn in
//   NUM_SLOTS         : concurrent note sprites
//   LANE_X0/LANE_SPACING : x of lane 0 and x pitch between lanes
//   FIFO_DEPTH        : spawn queue entries (power of 2)
package strum_vga_pkg;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int SPRITE_SIZE  = 51;
    localparam int NUM_LANES    = 4;
    localparam int NUM_SLOTS    = 4;
    localparam int LANE_X0      = 0;
    localparam int LANE_SPACING = 80;
    localparam int FIFO_DEPTH   = 8;

    localparam int SLOT_IW      = $clog2(NUM_SLOTS);
    localparam int LANE_W       = $clog2(NUM_LANES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        SPAWN  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/spawn_fifo.sv
// Synchronous FIFO holding pending note-spawn lanes.
//   clk, reset : system clock, async active-high reset
//   push_i/din_i : write strobe and data (ignored when full)
//   pop_i/dout_o : read strobe (ignored when empty) and head-of-queue data
//   full_o/empty_o : derived from the registered occupancy count
module spawn_fifo
    import strum_vga_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int DW    = LANE_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    // Full comes from the registered count only, so a push at full is
    // refused even when a pop happens in the same cycle.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/note_sprite_scheduler.sv
// Falling-note sprite scheduler for the VGA overlay stage.
// Queues spawn requests, runs one advance/retire/spawn pass per frame edge,
// and answers per-pixel hit queries with the overlay RAM address.
//   clk, reset        : system clock, async active-high reset
//   frame_tick        : screen-end level; its rising edge starts a frame pass
//   speed             : pixels per frame, latched at the accepted frame edge
//   spawn_valid/lane  : spawn request in, spawn_ready = queue not full
//   pix_x/pix_y       : pixel being drawn
//   hit_valid/hit_addr: registered hit result for the previous clk's pixel
//   miss_pulse        : one cycle per note retired at the bottom
//   active_mask       : per-slot active flags
//   busy              : frame pass in progress
//
// state  | meaning
// IDLE   | waiting for a frame_tick rising edge
// UPDATE | advancing/retiring slot idx_q, one slot per cycle
// SPAWN  | popping one queued lane into the lowest free slot, if possible
module note_sprite_scheduler
    import strum_vga_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic [2:0]           speed,
    input  logic                 spawn_valid,
    input  logic [1:0]           spawn_lane,
    output logic                 spawn_ready,
    input  logic [9:0]           pix_x,
    input  logic [8:0]           pix_y,
    output logic                 hit_valid,
    output logic [11:0]          hit_addr,
    output logic                 miss_pulse,
    output logic [NUM_SLOTS-1:0] active_mask,
    output logic                 busy
);

    sched_state_e         state_q, state_d;
    logic                 frame_prev_q;
    logic [SLOT_IW-1:0]   idx_q, idx_d;
    logic [2:0]           speed_q, speed_d;
    logic [NUM_SLOTS-1:0] active_q, active_d;
    logic [9:0]           x_q [NUM_SLOTS];
    logic [9:0]           x_d [NUM_SLOTS];
    logic [8:0]           y_q [NUM_SLOTS];
    logic [8:0]           y_d [NUM_SLOTS];
    logic                 hit_valid_q, hit_valid_d;
    logic [11:0]          hit_addr_q, hit_addr_d;

    logic                 frame_edge;
    logic                 miss_d;
    logic [10:0]          y_sum;
    logic                 free_found;
    logic [SLOT_IW-1:0]   free_idx;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [1:0]           fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign frame_edge  = frame_tick && !frame_prev_q;
    assign spawn_ready = !fifo_full;
    assign fifo_push   = spawn_valid && spawn_ready;
    assign busy        = (state_q != IDLE);
    assign active_mask = active_q;
    assign miss_pulse  = miss_d;
    assign hit_valid   = hit_valid_q;
    assign hit_addr    = hit_addr_q;

    spawn_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (2)
    ) u_spawn_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .din_i   (spawn_lane),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            frame_prev_q <= 1'b0;
            idx_q        <= '0;
            speed_q      <= '0;
            active_q     <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                x_q[s] <= '0;
                y_q[s] <= '0;
            end
            hit_valid_q  <= 1'b0;
            hit_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            frame_prev_q <= frame_tick;
            idx_q        <= idx_d;
            speed_q      <= speed_d;
            active_q     <= active_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hit_valid_q  <= hit_valid_d;
            hit_addr_q   <= hit_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        speed_d    = speed_q;
        active_d   = active_q;
        x_d        = x_q;
        y_d        = y_q;
        miss_d     = 1'b0;
        fifo_pop   = 1'b0;
        y_sum      = '0;
        free_found = 1'b0;
        free_idx   = '0;

        // Descending scan so the lowest free index is the one left standing.
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (!active_q[s]) begin
                free_found = 1'b1;
                free_idx   = SLOT_IW'(s);
            end
        end

        case (state_q)
            IDLE: begin
                if (frame_edge) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                    speed_d = speed;
                end
            end
            UPDATE: begin
                // 11-bit sum so y near the bottom plus speed cannot wrap.
                y_sum = 11'(y_q[idx_q]) + 11'(speed_q);
                if (active_q[idx_q]) begin
                    if (y_sum >= 11'(SCREEN_H)) begin
                        active_d[idx_q] = 1'b0;
                        miss_d          = 1'b1;
                    end else begin
                        y_d[idx_q] = y_sum[8:0];
                    end
                end
                if (idx_q == SLOT_IW'(NUM_SLOTS - 1)) begin
                    state_d = SPAWN;
                end else begin
                    idx_d = idx_q + SLOT_IW'(1);
                end
            end
            SPAWN: begin
                if (!fifo_empty && free_found) begin
                    fifo_pop           = 1'b1;
                    active_d[free_idx] = 1'b1;
                    x_d[free_idx]      = 10'(LANE_X0 + int'(fifo_dout) * LANE_SPACING);
                    y_d[free_idx]      = '0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Hit test against live slot state; updates only run in vertical blank.
    always_comb begin
        hit_valid_d = 1'b0;
        hit_addr_d  = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (active_q[s]
                && ({1'b0, pix_x} >= {1'b0, x_q[s]})
                && ({1'b0, pix_x} <  ({1'b0, x_q[s]} + 11'(SPRITE_SIZE)))
                && ({1'b0, pix_y} >= {1'b0, y_q[s]})
                && ({1'b0, pix_y} <  ({1'b0, y_q[s]} + 10'(SPRITE_SIZE)))) begin
                hit_valid_d = 1'b1;
                hit_addr_d  = 12'(pix_x - x_q[s])
                            + 12'(pix_y - y_q[s]) * 12'(SPRITE_SIZE);
            end
        end
    end

endmodule
